// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester-side and memory-bus-side signals of the round-robin bus arbiter.
interface bus_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_write;
  logic [8*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   req_ack;
  logic              req_err;
  logic [7:0]        rsp_rdata;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              bus_read;
  logic              bus_write;
  logic [7:0]        bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_ready;
  logic [7:0]        bus_rdata;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, bus_ready, bus_rdata,
    output req_ack, req_err, rsp_rdata, grant, busy, bus_read, bus_write, bus_addr, bus_wdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, bus_ready, bus_rdata,
    input  req_ack, req_err, rsp_rdata, grant, busy, bus_read, bus_write, bus_addr, bus_wdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that runs one read/write per grant on a memory bus with timeout.
module bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           reset,
  bus_arbiter_if.master bif
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [OW-1:0] idx_t;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;
  state_t          state, state_nxt;
  idx_t            owner, last_owner, win;
  logic            found;
  logic            wr_l;
  logic            err_l;
  logic [7:0]      addr_l, wdata_l, rdata_q, cnt;
  logic [NREQ-1:0] onehot;
  // search starts just after the previous owner so every requester gets a turn
  always_comb begin
    win = last_owner;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++)
      if (!found && bif.req_valid[(int'(last_owner) + k) % NREQ]) begin
        win = idx_t'((int'(last_owner) + k) % NREQ);
        found = 1'b1;
      end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = |bif.req_valid ? ISSUE : IDLE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = bif.bus_ready ? CAPTURE : (cnt == 8'(TIMEOUT - 1)) ? DONE : WAIT;
      CAPTURE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= idx_t'(NREQ - 1);
      wr_l       <= 1'b0;
      err_l      <= 1'b0;
      addr_l     <= 8'h00;
      wdata_l    <= 8'h00;
      rdata_q    <= 8'h00;
      cnt        <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |bif.req_valid) begin
        owner   <= win;
        wr_l    <= bif.req_write[win];
        addr_l  <= bif.req_addr[int'(win)*8 +: 8];
        wdata_l <= bif.req_wdata[int'(win)*8 +: 8];
        err_l   <= 1'b0;
      end
      if (state == ISSUE) cnt <= 8'h00;
      if (state == WAIT && !bif.bus_ready) begin
        cnt <= cnt + 8'd1;
        if (cnt == 8'(TIMEOUT - 1)) begin
          err_l <= 1'b1;
          if (!wr_l) rdata_q <= 8'h00;
        end
      end
      if (state == CAPTURE && !wr_l) rdata_q <= bif.bus_rdata;
      if (state == DONE) last_owner <= owner;
    end
  end
  // outputs are gated by state so IDLE always presents reset values
  assign onehot        = NREQ'(1) << owner;
  assign bif.busy      = state != IDLE;
  assign bif.grant     = bif.busy ? onehot : '0;
  assign bif.bus_read  = state == ISSUE && !wr_l;
  assign bif.bus_write = state == ISSUE && wr_l;
  assign bif.bus_addr  = bif.busy ? addr_l : 8'h00;
  assign bif.bus_wdata = bif.busy ? wdata_l : 8'h00;
  assign bif.req_ack   = state == DONE ? onehot : '0;
  assign bif.req_err   = state == DONE && err_l;
  assign bif.rsp_rdata = state == DONE ? rdata_q : 8'h00;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized transactions checked against a transaction-level model.
module tb_bus_arbiter;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int npass = 0;
  int ntot = 0;
  logic [3:0] pend;
  int last;
  logic [7:0] mrd;
  logic       a_wr [4];
  logic [7:0] a_addr [4];
  logic [7:0] a_wd [4];
  bus_arbiter_if #(.NREQ(4)) bif();
  bus_arbiter #(.NREQ(4), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bif(bif.master));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  function automatic int pick(input logic [3:0] m, input int l);
    for (int k = 1; k <= 4; k++) if (m[(l + k) % 4]) return (l + k) % 4;
    return 0;
  endfunction
  task automatic drive_req();
    for (int i = 0; i < 4; i++) begin
      bif.req_write[i] = a_wr[i];
      bif.req_addr[i*8 +: 8] = a_addr[i];
      bif.req_wdata[i*8 +: 8] = a_wd[i];
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, bif.busy, 0);
    chk({tag, "_outs"}, {bif.grant, bif.req_ack, bif.req_err, bif.rsp_rdata, bif.bus_read, bif.bus_write, bif.bus_addr, bif.bus_wdata}, 0);
  endtask
  // one complete transaction for the round-robin winner of pend, starting at an IDLE negedge
  task automatic do_txn(input int dly, input logic stale, input logic keep, input logic scramble, input logic [7:0] rd);
    int w;
    logic tout;
    w = pick(pend, last);
    tout = dly >= TO;
    drive_req();
    bif.req_valid = pend;
    bif.bus_ready = stale;
    @(negedge clk);
    chk("issue_grant", bif.grant, 32'(1) << w);
    chk("issue_busy", bif.busy, 1);
    chk("issue_read", bif.bus_read, !a_wr[w]);
    chk("issue_write", bif.bus_write, a_wr[w]);
    chk("issue_addr", bif.bus_addr, a_addr[w]);
    chk("issue_wdata", bif.bus_wdata, a_wd[w]);
    chk("issue_ack", bif.req_ack, 0);
    bif.bus_ready = stale;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      chk("wait_strobe", {bif.bus_read, bif.bus_write}, 0);
      chk("wait_ack", bif.req_ack, 0);
      chk("wait_addr", bif.bus_addr, a_addr[w]);
      chk("wait_wdata", bif.bus_wdata, a_wd[w]);
      if (scramble) begin
        bif.req_valid = 4'($urandom);
        bif.req_write = 4'($urandom);
        bif.req_addr = $urandom;
        bif.req_wdata = $urandom;
      end
      bif.bus_ready = (c == dly);
      bif.bus_rdata = 8'($urandom);
      if (c == dly) break;
    end
    if (!tout) begin
      @(negedge clk);
      chk("capture_ack", bif.req_ack, 0);
      chk("capture_strobe", {bif.bus_read, bif.bus_write}, 0);
      bif.bus_ready = 1'($urandom);
      bif.bus_rdata = rd;
    end
    @(negedge clk);
    if (!a_wr[w]) mrd = tout ? 8'h00 : rd;
    chk("done_ack", bif.req_ack, 32'(1) << w);
    chk("done_err", bif.req_err, tout);
    chk("done_rdata", bif.rsp_rdata, mrd);
    chk("done_addr", bif.bus_addr, a_addr[w]);
    chk("done_grant", bif.grant, 32'(1) << w);
    last = w;
    if (!keep) pend[w] = 1'b0;
    bif.req_valid = pend;
    drive_req();
    bif.bus_ready = 1'($urandom);
    bif.bus_rdata = 8'($urandom);
    @(negedge clk);
    chk_idle("post_done");
    bif.bus_ready = 1'b0;
  endtask
  initial begin
    bif.req_valid = '0;
    bif.bus_ready = 1'b0;
    bif.bus_rdata = 8'h00;
    for (int i = 0; i < 4; i++) begin
      a_wr[i] = 1'b0;
      a_addr[i] = 8'(i * 16);
      a_wd[i] = 8'(i + 1);
    end
    drive_req();
    pend = '0;
    last = 3;
    mrd = 8'h00;
    #1;
    chk_idle("reset_async");
    repeat (2) @(negedge clk);
    chk_idle("reset_held");
    reset = 1'b0;
    @(negedge clk);
    chk_idle("idle_no_req");
    pend = 4'b1111;
    for (int i = 0; i < 4; i++) do_txn(0, 0, 0, 0, 8'($urandom));
    pend = 4'b0101;
    do_txn(1, 0, 0, 0, 8'h11);
    do_txn(2, 0, 0, 0, 8'h22);
    pend = 4'b0100;
    a_wr[2] = 1'b0;
    a_addr[2] = 8'h3C;
    do_txn(0, 0, 0, 0, 8'hA5);
    pend = 4'b0010;
    a_wr[1] = 1'b1;
    a_addr[1] = 8'h10;
    a_wd[1] = 8'h5A;
    do_txn(0, 0, 0, 0, 8'hEE);
    pend = 4'b0001;
    do_txn(99, 0, 0, 0, 8'h77);
    pend = 4'b0001;
    do_txn(TO - 1, 0, 0, 0, 8'h99);
    pend = 4'b1000;
    do_txn(3, 1, 0, 0, 8'hC3);
    pend = 4'b0010;
    drive_req();
    bif.req_valid = pend;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_idle("reset_in_wait");
    bif.req_valid = '0;
    pend = '0;
    @(negedge clk);
    chk_idle("reset_no_ack");
    reset = 1'b0;
    last = 3;
    @(negedge clk);
    chk_idle("after_reset");
    pend = 4'b1000;
    do_txn(0, 0, 0, 0, 8'h5C);
    for (int n = 0; n < 150; n++) begin
      if (pend == 0) begin
        bif.req_valid = '0;
        @(negedge clk);
        chk_idle("rand_idle");
      end
      if (pend == 0 || $urandom_range(0, 3) == 0) pend |= 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        a_wr[i] = 1'($urandom);
        a_addr[i] = 8'($urandom);
        a_wd[i] = 8'($urandom);
      end
      do_txn(($urandom_range(0, 4) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 4),
             1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom), 8'($urandom));
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
